// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: shares the register file write port between the ALU
// and load return paths, each with a one-entry holding buffer.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_W-1:0]        ld_rd,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     rg_wrt_en,
  output logic [ADDR_W-1:0]        rg_wrt_addr,
  output logic [DATA_W-1:0]        rg_wrt_data,
  output logic [(1<<ADDR_W)-1:0]   pending,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int NREG = 1 << ADDR_W;

  logic              alu_occ_q, alu_occ_d;
  logic [ADDR_W-1:0] alu_rd_q, alu_rd_d;
  logic [DATA_W-1:0] alu_data_q, alu_data_d;
  logic              ld_occ_q, ld_occ_d;
  logic [ADDR_W-1:0] ld_rd_q, ld_rd_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic              old_is_ld_q, old_is_ld_d;
  logic              last_grant_q, last_grant_d;  // 1 = LD
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic grant_alu, grant_ld;
  logic alu_load, ld_load;
  logic stalled;

  // Grant depends only on registered state, so ready never loops back to valid.
  always_comb begin
    grant_alu = 1'b0;
    grant_ld  = 1'b0;
    if (alu_occ_q && ld_occ_q) begin
      if (alu_rd_q == ld_rd_q) begin
        grant_ld = old_is_ld_q;
      end else begin
        grant_ld = !last_grant_q;
      end
      grant_alu = !grant_ld;
    end else begin
      grant_alu = alu_occ_q;
      grant_ld  = ld_occ_q;
    end
  end

  assign alu_ready = !alu_occ_q || grant_alu;
  assign ld_ready  = !ld_occ_q || grant_ld;

  // Writes to x0 complete the handshake but never occupy an entry.
  assign alu_load = alu_valid && alu_ready && (alu_rd != '0);
  assign ld_load  = ld_valid && ld_ready && (ld_rd != '0);

  assign stalled = (alu_occ_q && !grant_alu) || (ld_occ_q && !grant_ld);

  always_comb begin
    alu_occ_d    = alu_occ_q;
    alu_rd_d     = alu_rd_q;
    alu_data_d   = alu_data_q;
    ld_occ_d     = ld_occ_q;
    ld_rd_d      = ld_rd_q;
    ld_data_d    = ld_data_q;
    old_is_ld_d  = old_is_ld_q;
    last_grant_d = last_grant_q;
    stall_cnt_d  = stall_cnt_q;

    if (grant_alu) alu_occ_d = 1'b0;
    if (grant_ld)  ld_occ_d  = 1'b0;
    if (alu_load) begin
      alu_occ_d  = 1'b1;
      alu_rd_d   = alu_rd;
      alu_data_d = alu_data;
    end
    if (ld_load) begin
      ld_occ_d  = 1'b1;
      ld_rd_d   = ld_rd;
      ld_data_d = ld_data;
    end

    // A freshly loaded entry is always younger than one that was held.
    if (alu_occ_d && ld_occ_d) begin
      if (alu_load && ld_load) begin
        old_is_ld_d = 1'b0;
      end else if (alu_load) begin
        old_is_ld_d = 1'b1;
      end else if (ld_load) begin
        old_is_ld_d = 1'b0;
      end
    end else begin
      old_is_ld_d = ld_occ_d;
    end

    if (grant_alu || grant_ld) last_grant_d = grant_ld;

    if (stalled && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_occ_q    <= 1'b0;
      alu_rd_q     <= '0;
      alu_data_q   <= '0;
      ld_occ_q     <= 1'b0;
      ld_rd_q      <= '0;
      ld_data_q    <= '0;
      old_is_ld_q  <= 1'b0;
      last_grant_q <= 1'b1;
      stall_cnt_q  <= '0;
    end else begin
      alu_occ_q    <= alu_occ_d;
      alu_rd_q     <= alu_rd_d;
      alu_data_q   <= alu_data_d;
      ld_occ_q     <= ld_occ_d;
      ld_rd_q      <= ld_rd_d;
      ld_data_q    <= ld_data_d;
      old_is_ld_q  <= old_is_ld_d;
      last_grant_q <= last_grant_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign rg_wrt_en   = grant_alu || grant_ld;
  assign rg_wrt_addr = grant_alu ? alu_rd_q : (grant_ld ? ld_rd_q : '0);
  assign rg_wrt_data = grant_alu ? alu_data_q : (grant_ld ? ld_data_q : '0);
  assign stall_cnt   = stall_cnt_q;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_pending
    assign pending[gi] = (alu_occ_q && (alu_rd_q == ADDR_W'(gi))) ||
                         (ld_occ_q && (ld_rd_q == ADDR_W'(gi)));
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected writes are queued when the
// handshake is driven and popped whenever the write port fires.
module tb_rf_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  typedef logic [ADDR_W+DATA_W-1:0] wr_t;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   alu_valid = 1'b0;
  logic                   alu_ready;
  logic [ADDR_W-1:0]      alu_rd = '0;
  logic [DATA_W-1:0]      alu_data = '0;
  logic                   ld_valid = 1'b0;
  logic                   ld_ready;
  logic [ADDR_W-1:0]      ld_rd = '0;
  logic [DATA_W-1:0]      ld_data = '0;
  logic                   rg_wrt_en;
  logic [ADDR_W-1:0]      rg_wrt_addr;
  logic [DATA_W-1:0]      rg_wrt_data;
  logic [(1<<ADDR_W)-1:0] pending;
  logic [CNT_W-1:0]       stall_cnt;

  wr_t              exp_q[$];
  int               asserts = 0;
  int               fails = 0;
  logic [CNT_W-1:0] exp_stall = '0;
  logic [DATA_W-1:0] alu_pay, ld_pay;

  rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .rg_wrt_en(rg_wrt_en), .rg_wrt_addr(rg_wrt_addr), .rg_wrt_data(rg_wrt_data),
    .pending(pending), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic stall_inc();
    if (exp_stall != '1) exp_stall = exp_stall + 1'b1;
  endtask

  // Sample mid-cycle and check the write port against the scoreboard.
  task automatic settle(input logic exp_en);
    wr_t e;
    @(negedge clk);
    chk("wr_en", rg_wrt_en, exp_en);
    if (rg_wrt_en) begin
      asserts++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL wr_unexpected: observed write addr %0h data %0h, expected none",
               rg_wrt_addr, rg_wrt_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("write addr=%0d data=%08h", rg_wrt_addr, rg_wrt_data);
        chk("wr_addr", rg_wrt_addr, e[ADDR_W+DATA_W-1:DATA_W]);
        chk("wr_data", rg_wrt_data, e[DATA_W-1:0]);
      end
    end else begin
      chk("idle_addr", rg_wrt_addr, 0);
      chk("idle_data", rg_wrt_data, 0);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    alu_valid = 1'b0;
    ld_valid = 1'b0;
    exp_q.delete();
    exp_stall = '0;
    settle(1'b0);
    chk("rst_pending", pending, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_stall", stall_cnt, 0);
    adv();
    reset = 1'b0;
  endtask

  // Both producers stream continuously (rd 1 / rd 2) starting from empty
  // entries with LD as last grant; payload advances only on accept.
  task automatic contend(input int n);
    logic ear, elr;
    for (int k = 0; k < n; k++) begin
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = alu_pay;
      ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = ld_pay;
      ear = (k == 0) || (k % 2 == 1);
      elr = (k == 0) || (k % 2 == 0);
      settle(k != 0);
      chk("ct_alu_ready", alu_ready, ear);
      chk("ct_ld_ready", ld_ready, elr);
      chk("ct_stall", stall_cnt, exp_stall);
      chk("ct_pending", pending, (k == 0) ? 0 : 64'h6);
      if (ear) push(5'd1, alu_pay);
      if (elr) push(5'd2, ld_pay);
      adv();
      if (ear) alu_pay++;
      if (elr) ld_pay++;
      if (k != 0) stall_inc();
    end
    alu_valid = 1'b0;
    ld_valid = 1'b0;
    settle(1'b1);
    adv();
    stall_inc();
    settle(1'b1);
    adv();
    settle(1'b0);
    chk("ct_end_stall", stall_cnt, exp_stall);
    chk("ct_end_pending", pending, 0);
    adv();
  endtask

  initial begin
    alu_pay = 32'h100;
    ld_pay  = 32'h200;

    // Reset and idle
    do_reset();
    settle(1'b0);
    chk("idle_pending", pending, 0);
    chk("idle_alu_ready", alu_ready, 1);
    chk("idle_ld_ready", ld_ready, 1);
    chk("idle_stall", stall_cnt, 0);
    adv();

    // ALU stream rd 3,4,5 uncontended
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
    settle(1'b0); chk("st_ready0", alu_ready, 1); push(5'd3, 32'hA); adv();
    alu_rd = 5'd4; alu_data = 32'hB;
    settle(1'b1); chk("st_pend3", pending, 64'h8); chk("st_ready1", alu_ready, 1);
    push(5'd4, 32'hB); adv();
    alu_rd = 5'd5; alu_data = 32'hC;
    settle(1'b1); chk("st_pend4", pending, 64'h10); push(5'd5, 32'hC); adv();
    alu_valid = 1'b0;
    settle(1'b1); chk("st_pend5", pending, 64'h20); adv();
    settle(1'b0); chk("st_pend_end", pending, 0); chk("st_stall", stall_cnt, 0); adv();

    // Same edge, same rd; last grant is ALU so only age puts ALU first
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h11;
    ld_valid  = 1'b1; ld_rd  = 5'd7; ld_data  = 32'h22;
    settle(1'b0); push(5'd7, 32'h11); push(5'd7, 32'h22); adv();
    alu_valid = 1'b0; ld_valid = 1'b0;
    settle(1'b1);
    chk("se_alu_ready", alu_ready, 1); chk("se_ld_ready", ld_ready, 0);
    chk("se_pending", pending, 64'h80);
    adv(); stall_inc();
    settle(1'b1); chk("se_stall", stall_cnt, exp_stall); adv();
    settle(1'b0); adv();

    // LD loaded a cycle earlier than ALU, both to rd 7
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h55;
    ld_valid  = 1'b1; ld_rd  = 5'd7; ld_data  = 32'h44;
    settle(1'b0); push(5'd9, 32'h55); push(5'd7, 32'h44); adv();
    alu_rd = 5'd7; alu_data = 32'h66; ld_valid = 1'b0;
    settle(1'b1);
    chk("ag_alu_ready", alu_ready, 1); chk("ag_ld_ready", ld_ready, 0);
    push(5'd7, 32'h66); adv(); stall_inc();
    alu_valid = 1'b0;
    settle(1'b1);
    chk("ag_pending", pending, 64'h80);
    chk("ag_alu_ready2", alu_ready, 0); chk("ag_ld_ready2", ld_ready, 1);
    adv(); stall_inc();
    settle(1'b1); adv();
    settle(1'b0); chk("ag_stall", stall_cnt, exp_stall); adv();

    // Write to x0: handshake completes, nothing buffered
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    settle(1'b0); chk("x0_ready", alu_ready, 1); adv();
    alu_valid = 1'b0;
    settle(1'b0);
    chk("x0_pending", pending, 0); chk("x0_ready2", alu_ready, 1);
    chk("x0_stall", stall_cnt, exp_stall);
    adv();

    // Contended stream, alternating grants
    do_reset();
    contend(7);

    // Reset while both entries hold writes
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = alu_pay;
    ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = ld_pay;
    settle(1'b0); push(5'd1, alu_pay); push(5'd2, ld_pay); adv();
    alu_pay++; ld_pay++;
    alu_data = alu_pay;
    settle(1'b1); chk("mr_pending", pending, 64'h6); adv();
    do_reset();
    settle(1'b0); chk("mr_pending_after", pending, 0); chk("mr_stall", stall_cnt, 0); adv();

    // Saturating stall counter over 2^CNT_W+5 contended cycles
    do_reset();
    contend(22);
    settle(1'b0); chk("sat_stall", stall_cnt, 4'hF); adv();

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
